// File: rtl/test_monitor.sv
// Watches data-memory writes from a core under test and ends the test on a tohost
// write or a cycle timeout. Define TEST_MONITOR_TRACE_EN to keep a trace of recent writes.
module test_monitor #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = ADDR_WIDTH'(32'h0000_0040),
  parameter int unsigned           TIMEOUT_CYCLES = 500,
  parameter int unsigned           TRACE_DEPTH    = 8,
  localparam int unsigned          IdxW           = $clog2(TRACE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mon_write,
  input  logic [ADDR_WIDTH-1:0] mon_address,
  input  logic [DATA_WIDTH-1:0] mon_write_data,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [DATA_WIDTH-1:0] result_code,
  output logic [31:0]           cycle_count,
  output logic [15:0]           write_count,
  input  logic [IdxW-1:0]       trace_index,
  output logic                  trace_valid,
  output logic [ADDR_WIDTH-1:0] trace_address,
  output logic [DATA_WIDTH-1:0] trace_data
);

  typedef enum logic [1:0] {StRun, StPass, StFail, StTimeout} state_e;

  state_e                state_q, state_d;
  logic [31:0]           cycle_q, cycle_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  tohost_wr;
  logic                  run_wr;

  assign tohost_wr = mon_write && (mon_address == TOHOST_ADDR);
  assign run_wr    = (state_q == StRun) && mon_write;

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    wcnt_d   = wcnt_q;
    result_d = result_q;
    if (state_q == StRun) begin
      cycle_d = cycle_q + 32'd1;
      if (mon_write && (wcnt_q != 16'hFFFF)) begin
        wcnt_d = wcnt_q + 16'd1;
      end
      // A terminating write takes priority over a timeout in the same cycle.
      if (tohost_wr && (mon_write_data == DATA_WIDTH'(1))) begin
        state_d  = StPass;
        result_d = mon_write_data;
      end else if (tohost_wr && (mon_write_data != '0)) begin
        state_d  = StFail;
        result_d = mon_write_data;
      end else if (cycle_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d = StTimeout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      cycle_q  <= '0;
      wcnt_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      wcnt_q   <= wcnt_d;
      result_q <= result_d;
    end
  end

  assign pass        = (state_q == StPass);
  assign fail        = (state_q == StFail);
  assign timeout     = (state_q == StTimeout);
  assign done        = pass | fail | timeout;
  assign result_code = result_q;
  assign cycle_count = cycle_q;
  assign write_count = wcnt_q;

`ifdef TEST_MONITOR_TRACE_EN
  logic [ADDR_WIDTH-1:0] addr_mem [TRACE_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [TRACE_DEPTH];
  logic [IdxW-1:0]       wr_ptr_q;
  logic [IdxW:0]         fill_q;
  logic [IdxW-1:0]       rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (run_wr) begin
      wr_ptr_q <= wr_ptr_q + IdxW'(1);
      if (fill_q != (IdxW + 1)'(TRACE_DEPTH)) begin
        fill_q <= fill_q + (IdxW + 1)'(1);
      end
    end
  end

  // Storage carries no reset; fill_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && run_wr) begin
      addr_mem[wr_ptr_q] <= mon_address;
      data_mem[wr_ptr_q] <= mon_write_data;
    end
  end

  // Depth is a power of two, so the subtraction wraps around the ring for free.
  assign rd_ptr        = wr_ptr_q - IdxW'(1) - trace_index;
  assign trace_valid   = ({1'b0, trace_index} < fill_q);
  assign trace_address = trace_valid ? addr_mem[rd_ptr] : '0;
  assign trace_data    = trace_valid ? data_mem[rd_ptr] : '0;
`else
  logic unused_trace;
  assign unused_trace  = ^{trace_index, run_wr};
  assign trace_valid   = 1'b0;
  assign trace_address = '0;
  assign trace_data    = '0;
`endif

endmodule

// File: tb/tb_test_monitor.sv
// Directed self-checking bench for test_monitor with default parameters.
module tb_test_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        mon_write;
  logic [31:0] mon_address;
  logic [31:0] mon_write_data;
  logic        done, pass, fail, timeout;
  logic [31:0] result_code;
  logic [31:0] cycle_count;
  logic [15:0] write_count;
  logic [2:0]  trace_index;
  logic        trace_valid;
  logic [31:0] trace_address;
  logic [31:0] trace_data;

  int checks = 0;
  int errors = 0;

  test_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .mon_write      (mon_write),
    .mon_address    (mon_address),
    .mon_write_data (mon_write_data),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .timeout        (timeout),
    .result_code    (result_code),
    .cycle_count    (cycle_count),
    .write_count    (write_count),
    .trace_index    (trace_index),
    .trace_valid    (trace_valid),
    .trace_address  (trace_address),
    .trace_data     (trace_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mon_write = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    mon_write = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mon_write      = 1'b1;
    mon_address    = a;
    mon_write_data = d;
    tick();
    mon_write = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    mon_write      = 1'b1;
    mon_address    = 32'h40;
    mon_write_data = 32'h7;
    trace_index    = '0;
    repeat (4) tick();
    rst       = 1'b0;
    mon_write = 1'b0;
    checks++; if ({done, pass, fail, timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_status got %b want 0000", {done, pass, fail, timeout});
    end
    checks++; if (cycle_count !== 32'd0) begin
      errors++; $display("FAIL reset_cycles got %0d want 0", cycle_count);
    end
    checks++; if (write_count !== 16'd0) begin
      errors++; $display("FAIL reset_writes got %0d want 0", write_count);
    end
    checks++; if (result_code !== 32'd0) begin
      errors++; $display("FAIL reset_result got %0h want 0", result_code);
    end
    checks++; if (trace_valid !== 1'b0) begin
      errors++; $display("FAIL reset_trace_valid got %b want 0", trace_valid);
    end
  endtask

  task automatic test_pass();
    do_reset();
    idle(20);
    checks++; if (cycle_count !== 32'd20 || done !== 1'b0) begin
      errors++; $display("FAIL pass_pre got cyc=%0d done=%b want cyc=20 done=0", cycle_count, done);
    end
    wr(32'h40, 32'h1);
    checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin
      errors++; $display("FAIL pass_status got %b want 1100", {done, pass, fail, timeout});
    end
    checks++; if (result_code !== 32'd1 || cycle_count !== 32'd21 || write_count !== 16'd1) begin
      errors++; $display("FAIL pass_values got res=%0h cyc=%0d wc=%0d want res=1 cyc=21 wc=1",
                         result_code, cycle_count, write_count);
    end
    wr(32'h40, 32'h5);
    idle(3);
    checks++; if (pass !== 1'b1 || fail !== 1'b0 || result_code !== 32'd1 ||
                  cycle_count !== 32'd21 || write_count !== 16'd1) begin
      errors++; $display("FAIL pass_frozen got p=%b f=%b res=%0h cyc=%0d wc=%0d want 1 0 1 21 1",
                         pass, fail, result_code, cycle_count, write_count);
    end
  endtask

  task automatic test_fail();
    do_reset();
    idle(3);
    wr(32'h40, 32'h7);
    checks++; if ({done, pass, fail, timeout} !== 4'b1010 || result_code !== 32'd7) begin
      errors++; $display("FAIL fail_status got %b res=%0h want 1010 res=7",
                         {done, pass, fail, timeout}, result_code);
    end
    wr(32'h40, 32'h1);
    checks++; if (fail !== 1'b1 || pass !== 1'b0 || result_code !== 32'd7 ||
                  write_count !== 16'd1) begin
      errors++; $display("FAIL fail_sticky got f=%b p=%b res=%0h wc=%0d want 1 0 7 1",
                         fail, pass, result_code, write_count);
    end
  endtask

  task automatic test_zero_then_pass();
    do_reset();
    wr(32'h40, 32'h0);
    checks++; if (done !== 1'b0 || write_count !== 16'd1 || result_code !== 32'd0) begin
      errors++; $display("FAIL zero_ignored got done=%b wc=%0d res=%0h want 0 1 0",
                         done, write_count, result_code);
    end
    wr(32'h40, 32'h1);
    checks++; if (pass !== 1'b1 || write_count !== 16'd2 || cycle_count !== 32'd2) begin
      errors++; $display("FAIL zero_then_pass got p=%b wc=%0d cyc=%0d want 1 2 2",
                         pass, write_count, cycle_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    idle(499);
    checks++; if (cycle_count !== 32'd499 || done !== 1'b0) begin
      errors++; $display("FAIL timeout_pre got cyc=%0d done=%b want 499 0", cycle_count, done);
    end
    idle(1);
    checks++; if ({done, pass, fail, timeout} !== 4'b1001 || cycle_count !== 32'd500) begin
      errors++; $display("FAIL timeout_status got %b cyc=%0d want 1001 500",
                         {done, pass, fail, timeout}, cycle_count);
    end
    wr(32'h40, 32'h1);
    checks++; if (timeout !== 1'b1 || pass !== 1'b0 || cycle_count !== 32'd500 ||
                  write_count !== 16'd0) begin
      errors++; $display("FAIL timeout_frozen got t=%b p=%b cyc=%0d wc=%0d want 1 0 500 0",
                         timeout, pass, cycle_count, write_count);
    end
  endtask

  task automatic test_timeout_tie();
    do_reset();
    idle(499);
    wr(32'h40, 32'h1);
    checks++; if (pass !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd500 ||
                  result_code !== 32'd1) begin
      errors++; $display("FAIL tie_pass_wins got p=%b t=%b cyc=%0d res=%0h want 1 0 500 1",
                         pass, timeout, cycle_count, result_code);
    end
  endtask

  task automatic test_rst_in_pass();
    do_reset();
    checks++; if ({done, pass, fail, timeout} !== 4'b0000 || cycle_count !== 32'd0 ||
                  write_count !== 16'd0 || result_code !== 32'd0) begin
      errors++; $display("FAIL rerun_reset got st=%b cyc=%0d wc=%0d res=%0h want 0000 0 0 0",
                         {done, pass, fail, timeout}, cycle_count, write_count, result_code);
    end
    idle(2);
    wr(32'h40, 32'h1);
    checks++; if (pass !== 1'b1 || cycle_count !== 32'd3 || write_count !== 16'd1) begin
      errors++; $display("FAIL rerun_pass got p=%b cyc=%0d wc=%0d want 1 3 1",
                         pass, cycle_count, write_count);
    end
  endtask

  task automatic test_trace();
    do_reset();
    for (int i = 0; i < 10; i++) wr(32'(i), 32'h100 + 32'(i));
    checks++; if (done !== 1'b0 || write_count !== 16'd10 || cycle_count !== 32'd10) begin
      errors++; $display("FAIL trace_counts got done=%b wc=%0d cyc=%0d want 0 10 10",
                         done, write_count, cycle_count);
    end
`ifdef TEST_MONITOR_TRACE_EN
    for (int i = 0; i < 8; i++) begin
      trace_index = 3'(i);
      #1;
      checks++; if (trace_valid !== 1'b1 || trace_address !== 32'(9 - i) ||
                    trace_data !== 32'h109 - 32'(i)) begin
        errors++; $display("FAIL trace_entry%0d got v=%b a=%0h d=%0h want 1 %0h %0h", i,
                           trace_valid, trace_address, trace_data, 9 - i, 32'h109 - 32'(i));
      end
    end
    do_reset();
    trace_index = 3'd0;
    #1;
    checks++; if (trace_valid !== 1'b0) begin
      errors++; $display("FAIL trace_after_reset got %b want 0", trace_valid);
    end
    wr(32'h20, 32'hA);
    wr(32'h24, 32'hB);
    wr(32'h28, 32'hC);
    trace_index = 3'd2;
    #1;
    checks++; if (trace_valid !== 1'b1 || trace_address !== 32'h20 || trace_data !== 32'hA) begin
      errors++; $display("FAIL trace_oldest got v=%b a=%0h d=%0h want 1 20 a",
                         trace_valid, trace_address, trace_data);
    end
    trace_index = 3'd3;
    #1;
    checks++; if (trace_valid !== 1'b0) begin
      errors++; $display("FAIL trace_beyond_fill got %b want 0", trace_valid);
    end
`else
    for (int i = 0; i < 2; i++) begin
      trace_index = 3'(i * 5);
      #1;
      checks++; if (trace_valid !== 1'b0 || trace_address !== 32'd0 || trace_data !== 32'd0) begin
        errors++; $display("FAIL trace_tied%0d got v=%b a=%0h d=%0h want 0 0 0", i,
                           trace_valid, trace_address, trace_data);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_zero_then_pass();
    test_timeout();
    test_timeout_tie();
    test_rst_in_pass();
    test_trace();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of the monitored address bus.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of the monitored write data and result_code.
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h0000_0040: address whose write ends the test.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 500: number of run cycles before timeout, minimum 2.
REQ-005 SHALL have parameter TRACE_DEPTH, default 8: trace buffer entries, a power of two, minimum 2.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port mon_write, input, 1: data-memory write strobe from the core.
REQ-009 SHALL have port mon_address, input, ADDR_WIDTH: data-memory address.
REQ-010 SHALL have port mon_write_data, input, DATA_WIDTH: data-memory write data.
REQ-011 SHALL have port done, output, 1: the test has ended (pass, fail or timeout).
REQ-012 SHALL have ports pass, fail and timeout, each output, 1: one-hot end status.
REQ-013 SHALL have port result_code, output, DATA_WIDTH: the value of the terminating tohost write.
REQ-014 SHALL have port cycle_count, output, 32: number of cycles spent in RUN.
REQ-015 SHALL have port write_count, output, 16: number of writes observed in RUN.
REQ-016 SHALL have ports trace_index (input, log2(TRACE_DEPTH)), trace_valid (output, 1), trace_address (output, ADDR_WIDTH) and trace_data (output, DATA_WIDTH): the trace read port.

Function
REQ-017 SHALL implement the states RUN, PASS, FAIL and TIMEOUT, and SHALL enter RUN on reset.
REQ-018 In RUN, a cycle with mon_write=1, mon_address==TOHOST_ADDR and mon_write_data==1 SHALL move the block to PASS on that edge.
REQ-019 In RUN, a tohost write with mon_write_data other than 0 or 1 SHALL move the block to FAIL.
REQ-020 A tohost write with data 0 SHALL be ignored for state purposes but SHALL still be counted and traced.
REQ-021 On any terminating tohost write, result_code SHALL capture mon_write_data on the same edge.
REQ-022 In RUN, cycle_count SHALL increment by 1 every cycle.
REQ-023 When cycle_count==TIMEOUT_CYCLES-1 with no terminating write in that cycle, the block SHALL move to TIMEOUT.
REQ-024 If a terminating write and the timeout condition occur in the same cycle, the terminating write SHALL win.
REQ-025 In RUN, write_count SHALL increment on each mon_write=1 cycle and SHALL saturate at 16'hFFFF.
REQ-026 PASS, FAIL and TIMEOUT SHALL be sticky until rst.
REQ-027 In a terminal state, cycle_count, write_count, result_code and the trace buffer SHALL freeze, and mon_* inputs SHALL be ignored.
REQ-028 done SHALL equal pass|fail|timeout.
REQ-029 All status outputs SHALL be registered, so they are visible the cycle after the triggering edge.

Reset
REQ-030 rst=1 at a rising edge SHALL set state to RUN and clear done, pass, fail, timeout, result_code, cycle_count, write_count, the trace pointer and the trace fill count, including when asserted mid-run or in a terminal state.
REQ-031 While rst=1, writes SHALL NOT be counted or traced.

Configuration
REQ-032 With macro TEST_MONITOR_TRACE_EN defined, the block SHALL keep a circular buffer of the last TRACE_DEPTH RUN-state writes, storing address and data.
REQ-033 With the macro defined, trace_index 0 SHALL select the most recent write, and the read SHALL be combinational.
REQ-034 With the macro defined, trace_valid SHALL be 0 when trace_index is at or beyond the number of writes recorded; the buffer wraps by overwriting the oldest entry.
REQ-035 Without the macro, no trace storage SHALL exist, and trace_valid, trace_address and trace_data SHALL be tied to 0.

Verification
REQ-036 Reset, then write 0x1 to 0x40 at cycle 20 -> pass=1, done=1, result_code=1, cycle_count=21, all frozen thereafter.
REQ-037 Write 0x7 to 0x40 -> fail=1, result_code=7; a later write of 0x1 to 0x40 leaves fail=1 and pass=0.
REQ-038 No tohost write with TIMEOUT_CYCLES=500 -> timeout=1 after the edge where cycle_count=499; a tohost write of 0x1 in that same cycle gives pass=1 and timeout=0.
REQ-039 Write 0x0 to 0x40, then 0x1 to 0x40 -> state stays RUN after the first write, then PASS, with write_count=2.
REQ-040 With TEST_MONITOR_TRACE_EN and TRACE_DEPTH=8, ten writes to addresses 0..9 -> index 0 gives address 9, index 7 gives address 2, all valid; after reset, index 0 reads trace_valid=0.
REQ-041 Assert rst while in PASS -> the next cycle shows done=0 and counts 0, and a new test passes normally.
